uart: RTL and testbench

UART -- requirements
Module: uart

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tick_div.sv | 27 ++
 rtl/uart.sv | 228 ++++++++++++++++++++++
 tb/tb_uart.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART state encodings and bit-timing constants
package uart_pkg;

   typedef enum logic [2:0] {
      RX_IDLE          = 3'd0,
      RX_CHECK_START   = 3'd1,
      RX_READ_BITS     = 3'd2,
      RX_CHECK_STOP    = 3'd3,
      RX_DELAY_RESTART = 3'd4,
      RX_ERROR         = 3'd5,
      RX_RECEIVED      = 3'd6
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE          = 2'd0,
      TX_SENDING       = 2'd1,
      TX_DELAY_RESTART = 2'd2
   } tx_state_t;

   localparam logic [3:0] TICKS_PER_BIT  = 4'd4;
   localparam logic [3:0] HALF_BIT_TICKS = 4'd2;
   localparam logic [3:0] RESTART_TICKS  = 4'd8;
   localparam logic [3:0] DATA_BITS      = 4'd8;

endpackage

// File: rtl/uart_tick_div.sv
// rtl/uart_tick_div.sv - restartable oversample tick generator, one tick every CLOCK_DIVIDE clocks
module uart_tick_div #(
   parameter int CLOCK_DIVIDE = 1302
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int W = $clog2(CLOCK_DIVIDE + 1);
   localparam logic [W-1:0] RELOAD = W'(CLOCK_DIVIDE - 1);

   logic [W-1:0] cnt;

   // Restart realigns the first tick to CLOCK_DIVIDE clocks after the restart edge.
   always_ff @(posedge clk) begin
      if (rst || restart || cnt == '0) begin
         cnt <= RELOAD;
      end else begin
         cnt <= cnt - W'(1);
      end
   end

   assign tick = (cnt == '0);

endmodule

// File: rtl/uart.sv
// rtl/uart.sv - 8N1 UART, independent rx/tx FSMs; UART_STATE_DEBUG_EN exposes live FSM state codes
module uart
   import uart_pkg::*;
#(
   parameter int CLOCK_DIVIDE = 1302
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       tx,
   input  logic       transmit,
   input  logic [7:0] tx_byte,
   output logic       received,
   output logic [7:0] rx_byte,
   output logic       is_receiving,
   output logic       is_transmitting,
   output logic       recv_error,
   output logic [2:0] recv_state,
   output logic [1:0] tx_state
);

   logic rx_meta, rx_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   logic rx_tick, rx_restart, tx_tick, tx_restart;

   uart_tick_div #(.CLOCK_DIVIDE(CLOCK_DIVIDE)) u_rx_div (
      .clk     (clk),
      .rst     (rst),
      .restart (rx_restart),
      .tick    (rx_tick)
   );

   uart_tick_div #(.CLOCK_DIVIDE(CLOCK_DIVIDE)) u_tx_div (
      .clk     (clk),
      .rst     (rst),
      .restart (tx_restart),
      .tick    (tx_tick)
   );

   rx_state_t  rx_st, rx_st_n;
   logic [3:0] rx_cnt, rx_cnt_n, rx_bits, rx_bits_n;
   logic [7:0] rx_shift, rx_shift_n, rx_byte_q, rx_byte_n;
   logic       rx_expire;

   // Countdown reaches zero on this tick.
   assign rx_expire = rx_tick && (rx_cnt == 4'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_st     <= RX_IDLE;
         rx_cnt    <= 4'd0;
         rx_bits   <= 4'd0;
         rx_shift  <= 8'h00;
         rx_byte_q <= 8'h00;
      end else begin
         rx_st     <= rx_st_n;
         rx_cnt    <= rx_cnt_n;
         rx_bits   <= rx_bits_n;
         rx_shift  <= rx_shift_n;
         rx_byte_q <= rx_byte_n;
      end
   end

   always_comb begin
      rx_st_n    = rx_st;
      rx_cnt_n   = rx_cnt;
      rx_bits_n  = rx_bits;
      rx_shift_n = rx_shift;
      rx_byte_n  = rx_byte_q;
      rx_restart = 1'b0;
      if (rx_tick && rx_cnt != 4'd0) begin
         rx_cnt_n = rx_cnt - 4'd1;
      end
      case (rx_st)
         RX_IDLE: begin
            if (!rx_sync) begin
               rx_restart = 1'b1;
               rx_cnt_n   = HALF_BIT_TICKS;
               rx_st_n    = RX_CHECK_START;
            end
         end
         RX_CHECK_START: begin
            if (rx_expire) begin
               if (!rx_sync) begin
                  rx_cnt_n  = TICKS_PER_BIT;
                  rx_bits_n = DATA_BITS;
                  rx_st_n   = RX_READ_BITS;
               end else begin
                  rx_st_n = RX_ERROR;
               end
            end
         end
         RX_READ_BITS: begin
            if (rx_expire) begin
               rx_shift_n = {rx_sync, rx_shift[7:1]};
               rx_cnt_n   = TICKS_PER_BIT;
               rx_bits_n  = rx_bits - 4'd1;
               if (rx_bits == 4'd1) begin
                  rx_st_n = RX_CHECK_STOP;
               end
            end
         end
         RX_CHECK_STOP: begin
            if (rx_expire) begin
               if (rx_sync) begin
                  rx_byte_n = rx_shift;
                  rx_st_n   = RX_RECEIVED;
               end else begin
                  rx_st_n = RX_ERROR;
               end
            end
         end
         RX_RECEIVED: begin
            rx_st_n = RX_IDLE;
         end
         RX_ERROR: begin
            rx_cnt_n = RESTART_TICKS;
            rx_st_n  = RX_DELAY_RESTART;
         end
         RX_DELAY_RESTART: begin
            if (rx_expire) begin
               rx_st_n = RX_IDLE;
            end
         end
         default: begin
            rx_st_n = RX_IDLE;
         end
      endcase
   end

   // rx_byte is loaded on entry to RECEIVED so it is valid while received is high.
   assign received     = (rx_st == RX_RECEIVED);
   assign recv_error   = (rx_st == RX_ERROR);
   assign is_receiving = (rx_st != RX_IDLE);
   assign rx_byte      = rx_byte_q;

   tx_state_t  tx_st, tx_st_n;
   logic [3:0] tx_cnt, tx_cnt_n, tx_bits, tx_bits_n;
   logic [7:0] tx_shift, tx_shift_n;
   logic       tx_q, tx_n, tx_expire;

   assign tx_expire = tx_tick && (tx_cnt == 4'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_st    <= TX_IDLE;
         tx_cnt   <= 4'd0;
         tx_bits  <= 4'd0;
         tx_shift <= 8'h00;
         tx_q     <= 1'b1;
      end else begin
         tx_st    <= tx_st_n;
         tx_cnt   <= tx_cnt_n;
         tx_bits  <= tx_bits_n;
         tx_shift <= tx_shift_n;
         tx_q     <= tx_n;
      end
   end

   always_comb begin
      tx_st_n    = tx_st;
      tx_cnt_n   = tx_cnt;
      tx_bits_n  = tx_bits;
      tx_shift_n = tx_shift;
      tx_n       = tx_q;
      tx_restart = 1'b0;
      if (tx_tick && tx_cnt != 4'd0) begin
         tx_cnt_n = tx_cnt - 4'd1;
      end
      case (tx_st)
         TX_IDLE: begin
            if (transmit) begin
               tx_shift_n = tx_byte;
               tx_n       = 1'b0;
               tx_cnt_n   = TICKS_PER_BIT;
               tx_bits_n  = DATA_BITS;
               tx_restart = 1'b1;
               tx_st_n    = TX_SENDING;
            end
         end
         TX_SENDING: begin
            if (tx_expire) begin
               if (tx_bits != 4'd0) begin
                  tx_n       = tx_shift[0];
                  tx_shift_n = {1'b0, tx_shift[7:1]};
                  tx_cnt_n   = TICKS_PER_BIT;
                  tx_bits_n  = tx_bits - 4'd1;
               end else begin
                  // Stop bit and inter-frame gap share one two-bit-time countdown.
                  tx_n     = 1'b1;
                  tx_cnt_n = RESTART_TICKS;
                  tx_st_n  = TX_DELAY_RESTART;
               end
            end
         end
         TX_DELAY_RESTART: begin
            if (tx_expire) begin
               tx_st_n = TX_IDLE;
            end
         end
         default: begin
            tx_st_n = TX_IDLE;
         end
      endcase
   end

   assign tx              = tx_q;
   assign is_transmitting = (tx_st != TX_IDLE);

`ifdef UART_STATE_DEBUG_EN
   assign recv_state = rx_st;
   assign tx_state   = tx_st;
`else
   assign recv_state = 3'd0;
   assign tx_state   = 2'd0;
`endif

endmodule

// File: tb/tb_uart.sv
// tb/tb_uart.sv - directed self-checking bench for uart at CLOCK_DIVIDE=4 (16 clk per bit)
module tb_uart;

   logic       clk = 1'b0;
   logic       rst, rx, transmit;
   logic [7:0] tx_byte;
   logic       tx, received, is_receiving, is_transmitting, recv_error;
   logic [7:0] rx_byte;
   logic [2:0] recv_state;
   logic [1:0] tx_state;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   uart #(.CLOCK_DIVIDE(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .rx              (rx),
      .tx              (tx),
      .transmit        (transmit),
      .tx_byte         (tx_byte),
      .received        (received),
      .rx_byte         (rx_byte),
      .is_receiving    (is_receiving),
      .is_transmitting (is_transmitting),
      .recv_error      (recv_error),
      .recv_state      (recv_state),
      .tx_state        (tx_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts at a negedge; n counts negedges after the accepting edge.
   task automatic send_check(input logic [7:0] b, input logic [9:0] frame, input bit poke);
      transmit = 1'b1;
      tx_byte  = b;
      @(negedge clk);
      transmit = 1'b0;
      for (int n = 0; n <= 176; n++) begin
         if (poke && n == 50) begin
            transmit = 1'b1;
            tx_byte  = 8'hFF;
         end
         if (poke && n == 51) transmit = 1'b0;
         if (n < 160) check("tx_bit", tx, frame[n/16]);
         if (n == 0 || n == 175) check("tx_busy", is_transmitting, 1'b1);
         if (n == 176) check("tx_done", is_transmitting, 1'b0);
`ifdef UART_STATE_DEBUG_EN
         if (n == 0) check("tx_state_sending", tx_state, 2'd1);
         if (n == 150) check("tx_state_delay", tx_state, 2'd2);
`endif
         if (n < 176) @(negedge clk);
      end
   endtask

   task automatic rx_frame(input string tag, input logic [9:0] frame,
                           input int exp_rcv, input int exp_err, input logic [7:0] exp_byte);
      int n_rcv, n_err;
      n_rcv = 0;
      n_err = 0;
      for (int n = 0; n < 224; n++) begin
         rx = (n < 160) ? frame[n/16] : 1'b1;
         @(negedge clk);
         if (received) begin
            n_rcv++;
            check({tag, "_byte_at_pulse"}, rx_byte, exp_byte);
         end
         if (recv_error) n_err++;
      end
      check({tag, "_received_cycles"}, n_rcv, exp_rcv);
      check({tag, "_error_cycles"}, n_err, exp_err);
      check({tag, "_rx_byte"}, rx_byte, exp_byte);
      check({tag, "_rx_idle"}, is_receiving, 1'b0);
   endtask

   initial begin
      int  busy, n_err, n_rcv;
      bit  saw_err, saw_delay;

      rst      = 1'b1;
      rx       = 1'b1;
      transmit = 1'b0;
      tx_byte  = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1'b1);
      check("rst_is_tx", is_transmitting, 1'b0);
      check("rst_is_rx", is_receiving, 1'b0);
      check("rst_received", received, 1'b0);
      check("rst_recv_error", recv_error, 1'b0);
      check("rst_rx_byte", rx_byte, 8'h00);
      check("rst_recv_state", recv_state, 3'd0);
      check("rst_tx_state", tx_state, 2'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      send_check(8'hAA, 10'b1101010100, 1'b0);
      send_check(8'h55, 10'b1010101010, 1'b1);
      repeat (20) @(negedge clk);
      check("no_retrigger", is_transmitting, 1'b0);
      check("idle_tx_high", tx, 1'b1);

      transmit = 1'b1;
      tx_byte  = 8'h00;
      @(negedge clk);
      transmit = 1'b0;
      repeat (30) @(negedge clk);
      check("mid_frame_tx_low", tx, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("rst_abort_tx", tx, 1'b1);
      check("rst_abort_busy", is_transmitting, 1'b0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      rx_frame("rx_a5", 10'b1101001010, 1, 0, 8'hA5);
      rx_frame("rx_3c", 10'b1001111000, 1, 0, 8'h3C);
      rx_frame("rx_badstop", 10'b0000011110, 0, 1, 8'h3C);

      busy      = 0;
      n_err     = 0;
      n_rcv     = 0;
      saw_err   = 1'b0;
      saw_delay = 1'b0;
      for (int n = 0; n < 80; n++) begin
         rx = (n < 4) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (is_receiving) busy++;
         if (recv_error) n_err++;
         if (received) n_rcv++;
         if (recv_state == 3'd5) saw_err = 1'b1;
         if (recv_state == 3'd4 && saw_err) saw_delay = 1'b1;
      end
      check("glitch_error_cycles", n_err, 1);
      check("glitch_received", n_rcv, 0);
      check("glitch_busy_cycles", busy, 40);
      check("glitch_rx_byte", rx_byte, 8'h3C);
      check("glitch_rx_idle", is_receiving, 1'b0);
      check("glitch_state_idle", recv_state, 3'd0);
`ifdef UART_STATE_DEBUG_EN
      check("glitch_saw_error_state", saw_err, 1'b1);
      check("glitch_saw_delay_state", saw_delay, 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
